// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for seq_multiplier: FSM state encoding and step-counter sizing.
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // A single-step configuration still needs a 1-bit counter.
   function automatic int step_cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// mul_step: one shift-add iteration, acc + (mcand * b_chunk) << (BITS_PER_CYCLE * step).
module mul_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2,
   parameter int STEP_W         = 4
) (
   input  logic [2*WIDTH-1:0]        i_acc,
   input  logic [WIDTH-1:0]          i_mcand,
   input  logic [BITS_PER_CYCLE-1:0] i_b_chunk,
   input  logic [STEP_W-1:0]         i_step,
   output logic [2*WIDTH-1:0]        o_acc_next
);
   localparam int PW = WIDTH + BITS_PER_CYCLE;

   logic [PW-1:0]      w_terms [BITS_PER_CYCLE];
   logic [PW-1:0]      w_partial;
   logic [2*WIDTH-1:0] w_partial_ext;
   logic [31:0]        w_shamt;

   genvar gi;
   generate
      for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
         assign w_terms[gi] = i_b_chunk[gi] ? (PW'(i_mcand) << gi) : '0;
      end
   endgenerate

   // mcand * (2^K - 1) < 2^(WIDTH+K), so the partial sum never overflows PW bits.
   always_comb begin
      w_partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_partial = w_partial + w_terms[i];
      end
   end

   assign w_shamt       = 32'(i_step) * 32'(BITS_PER_CYCLE);
   assign w_partial_ext = (2*WIDTH)'(w_partial);
   assign o_acc_next    = i_acc + (w_partial_ext << w_shamt);

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTH x WIDTH -> 2*WIDTH multiplier with valid/ready channels.
// Optional MUL_EARLY_EXIT_EN: RUN ends once the remaining multiplier bits are all zero.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_hi,
   output logic [WIDTH-1:0] rsp_lo,
   output logic             busy
);
   localparam int STEPS  = WIDTH / BITS_PER_CYCLE;
   localparam int STEP_W = step_cnt_width(STEPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   mul_state_t         r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_neg;
   logic [STEP_W-1:0]  r_step;
   logic [2*WIDTH-1:0] r_acc;

   logic               w_req_xfer;
   logic               w_last;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [WIDTH-1:0]   w_mplier_next;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_product;

   assign req_ready  = (r_state == MUL_IDLE) | ((r_state == MUL_DONE) & rsp_ready);
   assign rsp_valid  = (r_state == MUL_DONE);
   assign busy       = (r_state == MUL_RUN) | (r_state == MUL_DONE);
   assign rsp_hi     = r_hi;
   assign rsp_lo     = r_lo;
   assign w_req_xfer = req_valid & req_ready;

   // Magnitudes are held unsigned; |-2^(W-1)| wraps to 2^(W-1), which is exactly right.
   assign w_a_neg = req_signed & req_a[WIDTH-1];
   assign w_b_neg = req_signed & req_b[WIDTH-1];
   assign w_a_abs = w_a_neg ? -req_a : req_a;
   assign w_b_abs = w_b_neg ? -req_b : req_b;

   assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
   assign w_product     = r_neg ? -w_acc_next : w_acc_next;

`ifdef MUL_EARLY_EXIT_EN
   assign w_last = (r_step == LAST_STEP) | (w_mplier_next == '0);
`else
   assign w_last = (r_step == LAST_STEP);
`endif

   mul_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .STEP_W         (STEP_W)
   ) u_step (
      .i_acc      (r_acc),
      .i_mcand    (r_mcand),
      .i_b_chunk  (r_mplier[BITS_PER_CYCLE-1:0]),
      .i_step     (r_step),
      .o_acc_next (w_acc_next)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state  <= MUL_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_step   <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (w_req_xfer) begin
         // Only reachable from IDLE, or from DONE when the response is taken on the same edge.
         r_mcand  <= w_a_abs;
         r_mplier <= w_b_abs;
         r_neg    <= w_a_neg ^ w_b_neg;
         r_step   <= '0;
         r_acc    <= '0;
         r_state  <= MUL_RUN;
      end else begin
         case (r_state)
            MUL_IDLE: ;
            MUL_RUN: begin
               r_acc    <= w_acc_next;
               r_mplier <= w_mplier_next;
               r_step   <= r_step + 1'b1;
               if (w_last) begin
                  r_hi    <= w_product[2*WIDTH-1:WIDTH];
                  r_lo    <= w_product[WIDTH-1:0];
                  r_state <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               if (rsp_ready) begin
                  r_state <= MUL_IDLE;
               end
            end
            default: r_state <= MUL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: products, latency, backpressure, busy-ignore, abort.
module tb_seq_multiplier;
   localparam int W = 32;
   localparam int K = 2;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_signed = 1'b0;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_hi;
   logic [W-1:0] rsp_lo;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(K)) dut (
      .clk        (clk),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_signed (req_signed),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hi     (rsp_hi),
      .rsp_lo     (rsp_lo),
      .busy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges from request transfer (counted as edge 1) until rsp_valid is seen.
   function automatic int exp_latency(input logic sgn, input logic [W-1:0] b);
      logic [W-1:0] babs;
      int msb;
      int early;
      babs = (sgn && b[W-1]) ? -b : b;
      msb = -1;
      for (int i = 0; i < W; i++) if (babs[i]) msb = i;
      early = (msb < 0) ? 2 : (msb + K) / K + 1;
`ifdef MUL_EARLY_EXIT_EN
      return early;
`else
      return (early > 0) ? W / K + 1 : 0;
`endif
   endfunction

   task automatic issue(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      req_signed = sgn;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s req_ready: got %b, required 1 within 50 cycles", tag, req_ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int n0, input int lat);
      int n = n0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n !== lat) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, required %0d", tag, n, lat);
      end
   endtask

   task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp_p);
      issue(tag, sgn, a, b);
      wait_rsp(tag, 1, exp_latency(sgn, b));
      checks++;
      if ({rsp_hi, rsp_lo} !== exp_p) begin
         errors++;
         $display("FAIL %s product: got %h_%h, required %h", tag, rsp_hi, rsp_lo, exp_p);
      end
      $display("op %-10s signed=%0b a=%h b=%h -> hi=%h lo=%h", tag, sgn, a, b, rsp_hi, rsp_lo);
      tick();
      checks++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL %s after consume {valid,ready,busy}: got %b, required 010", tag, {rsp_valid, req_ready, busy});
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      tick();
      checks++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset {ready,valid,busy}: got %b, required 100", {req_ready, rsp_valid, busy});
      end
      checks++;
      if ({rsp_hi, rsp_lo} !== 64'h0) begin
         errors++;
         $display("FAIL reset product: got %h_%h, required 0", rsp_hi, rsp_lo);
      end
      tick();
      clr = 1'b0;
      tick();
      $display("op reset     released");
   endtask

   task automatic test_unsigned();
      run_op("u355x113", 1'b0, 32'd355, 32'd113, 64'h0000_0000_0000_9CB3);
      run_op("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("u_8000x2", 1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
      run_op("u_b_one", 1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 64'h0000_0000_DEAD_BEEF);
      run_op("u_b_zero", 1'b0, 32'h0000_1234, 32'h0000_0000, 64'h0);
   endtask

   task automatic test_signed();
      run_op("s_min_x2", 1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000);
      run_op("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run_op("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("s_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0);
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b0;
      issue("bp", 1'b0, 32'd355, 32'd113);
      wait_rsp("bp", 1, exp_latency(1'b0, 32'd113));
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, req_ready, busy} !== 3'b101 || {rsp_hi, rsp_lo} !== 64'h9CB3) begin
            errors++;
            $display("FAIL bp hold cycle %0d: got flags=%b p=%h_%h, required flags=101 p=9cb3",
                     i, {rsp_valid, req_ready, busy}, rsp_hi, rsp_lo);
         end
         tick();
      end
      $display("op bp        held 5 cycles hi=%h lo=%h", rsp_hi, rsp_lo);
      req_signed = 1'b1;
      req_a      = 32'hFFFF_FFFF;
      req_b      = 32'hFFFF_FFFF;
      req_valid  = 1'b1;
      rsp_ready  = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b req_ready in DONE with rsp_ready: got %b, required 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, busy, req_ready} !== 3'b010) begin
         errors++;
         $display("FAIL b2b after accept {valid,busy,ready}: got %b, required 010", {rsp_valid, busy, req_ready});
      end
      checks++;
      if ({rsp_hi, rsp_lo} !== 64'h9CB3) begin
         errors++;
         $display("FAIL b2b old product held: got %h_%h, required 9cb3", rsp_hi, rsp_lo);
      end
      wait_rsp("b2b", 1, exp_latency(1'b1, 32'hFFFF_FFFF));
      checks++;
      if ({rsp_hi, rsp_lo} !== 64'h1) begin
         errors++;
         $display("FAIL b2b product: got %h_%h, required 1", rsp_hi, rsp_lo);
      end
      $display("op b2b       signed -1*-1 -> hi=%h lo=%h", rsp_hi, rsp_lo);
      tick();
   endtask

   task automatic test_ignore_busy();
      issue("busy", 1'b1, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
      tick(); tick(); tick();
      req_signed = 1'b0;
      req_a      = 32'd5;
      req_b      = 32'd5;
      req_valid  = 1'b1;
      #1;
      checks++;
      if ({req_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL busy {ready,busy} in RUN: got %b, required 01", {req_ready, busy});
      end
      tick(); tick();
      req_valid = 1'b0;
      wait_rsp("busy", 6, exp_latency(1'b1, 32'h7FFF_FFFF));
      checks++;
      if ({rsp_hi, rsp_lo} !== 64'hFFFF_FFFE_8000_0003) begin
         errors++;
         $display("FAIL busy product: got %h_%h, required fffffffe80000003", rsp_hi, rsp_lo);
      end
      $display("op busy      -3*0x7fffffff -> hi=%h lo=%h", rsp_hi, rsp_lo);
      tick();
   endtask

   task automatic test_clr_abort();
      logic seen_valid = 1'b0;
      issue("clr", 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
      for (int i = 0; i < 7; i++) tick();
      clr = 1'b1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, busy} !== 3'b100 || {rsp_hi, rsp_lo} !== 64'h0) begin
         errors++;
         $display("FAIL clr abort: got flags=%b p=%h_%h, required flags=100 p=0",
                  {req_ready, rsp_valid, busy}, rsp_hi, rsp_lo);
      end
      tick();
      clr = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (rsp_valid === 1'b1) seen_valid = 1'b1;
         tick();
      end
      checks++;
      if ({seen_valid, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL clr post-abort {seen_valid,ready}: got %b, required 01", {seen_valid, req_ready});
      end
      $display("op clr       aborted in RUN cycle 8");
      run_op("post_clr", 1'b0, 32'd355, 32'd113, 64'h9CB3);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_ignore_busy();
      test_clr_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
